sfq_and2_stim_tx: RTL

Synthesizable transmitter/checker that drives a clocked two-input RSFQ gate model using the toggle encoding our cells consume: every rising or falling edge on a line is one SFQ pulse. Each accepted command emits data pulses on `a`/`b`, then one SFQ clock pulse, then watches the gate's toggle-encoded output `q` and reports whether exactly the expected AND result arrived. It sits between a bench or host sequencer and cells such as the two-input AND, and guarantees the setup and hold separations those cells flag as critical-timing violations.

---
 rtl/sfq_stim_pkg.sv | 21 ++
 rtl/sfq_toggle_rx.sv | 28 ++
 rtl/sfq_and2_stim_tx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sfq_stim_pkg.sv
// Shared types and helpers for the SFQ gate stimulus transmitter.
// FSM states, counter sizing and q-pulse saturation limit.
package sfq_stim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLKP,
    WINDOW,
    REPORT
  } sfq_state_e;

  localparam int CNT_SAT = 2;

  function automatic int cnt_w(int s, int h);
    int m;
    m = (s > h) ? s : h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sfq_toggle_rx.sv
// Toggle-encoded line receiver: 2-flop synchronizer plus XOR edge
// detector giving a one-cycle pulse per line transition.
module sfq_toggle_rx (
  input  logic clk,
  input  logic rst_n,
  input  logic q_in,
  output logic pulse
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= q_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse = s2_q ^ s3_q;

endmodule

// File: rtl/sfq_and2_stim_tx.sv
// Drives a/b data pulses and one SFQ clock pulse into a clocked AND
// gate, then checks the toggle-encoded q response in a fixed window.
module sfq_and2_stim_tx
  import sfq_stim_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 6,
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_a,
  input  logic             cmd_b,
  output logic             sfq_a,
  output logic             sfq_b,
  output logic             sfq_clk,
  input  logic             q_in,
  output logic             rsp_valid,
  output logic             rsp_q,
  output logic             rsp_match,
  output logic [ERR_W-1:0] err_count
);

  localparam int CW = cnt_w(SETUP_CYC, HOLD_CYC);

  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("SETUP_CYC must be >= 1");
  end
  if (HOLD_CYC < 3) begin : g_bad_hold
    $error("HOLD_CYC must be >= 3");
  end

  sfq_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       qcnt_q;
  logic [1:0]       qcnt_d;
  logic             match_d;
  logic             a_q;
  logic             b_q;
  logic             rdy_q;
  logic             sa_q;
  logic             sb_q;
  logic             sc_q;
  logic             rv_q;
  logic             rq_q;
  logic             rm_q;
  logic [ERR_W-1:0] err_q;
  logic             pulse;

  sfq_toggle_rx u_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .q_in  (q_in),
    .pulse (pulse)
  );

  always_comb begin
    qcnt_d = qcnt_q;
    if (pulse && qcnt_q != 2'(CNT_SAT))
      qcnt_d = qcnt_q + 2'd1;
    match_d = (qcnt_q <= 2'd1) &&
              ((qcnt_q == 2'd1) == (a_q & b_q));
  end

  // The window counter runs HOLD_CYC-2 in WINDOW because CLKP
  // already samples the first of the HOLD_CYC counted cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qcnt_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      rdy_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sc_q    <= 1'b0;
      rv_q    <= 1'b0;
      rq_q    <= 1'b0;
      rm_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      rv_q <= 1'b0;
      rq_q <= 1'b0;
      rm_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid && rdy_q) begin
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            sa_q    <= sa_q ^ cmd_a;
            sb_q    <= sb_q ^ cmd_b;
            cnt_q   <= CW'(SETUP_CYC - 1);
            rdy_q   <= 1'b0;
            state_q <= SETUP;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            sc_q    <= ~sc_q;
            state_q <= CLKP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        CLKP: begin
          qcnt_q  <= {1'b0, pulse};
          cnt_q   <= CW'(HOLD_CYC - 2);
          state_q <= WINDOW;
        end
        WINDOW: begin
          qcnt_q <= qcnt_d;
          if (cnt_q == '0)
            state_q <= REPORT;
          else
            cnt_q <= cnt_q - 1'b1;
        end
        REPORT: begin
          rv_q <= 1'b1;
          rq_q <= (qcnt_q == 2'd1);
          rm_q <= match_d;
          if (!match_d && err_q != '1)
            err_q <= err_q + 1'b1;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = rdy_q;
  assign sfq_a     = sa_q;
  assign sfq_b     = sb_q;
  assign sfq_clk   = sc_q;
  assign rsp_valid = rv_q;
  assign rsp_q     = rq_q;
  assign rsp_match = rm_q;
  assign err_count = err_q;

endmodule
